idex_stage: RTL and testbench
=============================

Name: idex_stage

Overview:
- Decode-to-execute pipeline stage, directly upstream of the ALU.
- Registers decoded micro-ops in a 2-entry skid buffer with a valid/ready handshake.
- While an entry is held, it keeps its register-source values current by snooping the write-back bus.
- Selects op1/op2 (with a MEM-stage bypass) and presents aluop, op1 and op2 to the ALU every cycle the stage is valid.

Parameters:
XLEN, 64, datapath width (matches RegBus)
ALUOP_W, 4, ALU opcode width (matches aluopLength)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid_i_idex  in  1  decode has a micro-op
in_ready_o_idex  out  1  stage can accept
pc_i_idex  in  XLEN  instruction PC
rs1_i_idex / rs2_i_idex  in  5 each  source indices
rs1_data_i_idex / rs2_data_i_idex  in  XLEN each  regfile read data
imm_i_idex  in  XLEN  sign-extended immediate
aluop_i_idex  in  ALUOP_W  ALU opcode
op1_sel_i_idex  in  2  00 rs1, 01 pc, 10 zero
op2_sel_i_idex  in  2  00 rs2, 01 imm, 10 constant 4
rd_i_idex  in  5  destination
rd_wen_i_idex  in  1  destination write enable
flush_i_idex  in  1  redirect: kill all held entries
mem_wen_i_idex  in  1  MEM-stage result valid for bypass
mem_rd_i_idex  in  5  MEM-stage destination
mem_data_i_idex  in  XLEN  MEM-stage result
wb_wen_i_idex  in  1  regfile write this cycle
wb_rd_i_idex  in  5  write-back destination
wb_data_i_idex  in  XLEN  write-back data
out_valid_o_idex  out  1  head entry valid
out_ready_i_idex  in  1  execute consumes head
aluop_o_idex  out  ALUOP_W  to ALU
op1_o_idex / op2_o_idex  out  XLEN each  to ALU
store_data_o_idex  out  XLEN  bypassed rs2 value
pc_o_idex  out  XLEN  head PC
rd_o_idex  out  5  head destination
rd_wen_o_idex  out  1  head destination write enable (0 when out_valid is 0)

Behaviour:
- Storage: two slots, head (H) and skid (S), each with a valid bit.
- in_ready = ~S.valid, driven from a register only; no combinational path from out_ready_i.
- Accept when in_valid & in_ready. Pop when out_valid & out_ready.
- Slot fill rules:
  - Accept without pop: the entry goes to H if H is empty or H is popping, otherwise to S.
  - Pop with S valid: S moves to H.
  - Accept and pop with S empty: the new entry goes to H.
  - Accept with S valid is impossible, because in_ready is 0.
- Latency: 1 cycle from accept to out_valid when empty; throughput 1 per cycle with out_ready held at 1.
- Capture forwarding:
  - If wb_wen & wb_rd==rsX & rsX!=0 on the accept cycle, store wb_data instead of rsX_data.
- Snoop:
  - Every cycle, for each valid slot and each source X, if wb_wen & wb_rd==rsX & rsX!=0, the stored rsX value is replaced by wb_data.
  - Snoop and a slot move in the same cycle: the moved entry carries the snooped value.
- Output bypass (combinational on H):
  - srcX = (mem_wen & mem_rd==rsX & rsX!=0) ? mem_data : stored rsX.
  - op1 = sel 00 src1 / 01 pc / 10 0 / 11 0.
  - op2 = sel 00 src2 / 01 imm / 10 64'd4 / 11 0.
  - store_data = src2.
- Register x0: index 0 always reads the stored value. That value is 0, since the regfile returns 0 and snooping on rd 0 is ignored.
- Flush:
  - Clears H.valid and S.valid next edge; in_ready becomes 1.
  - A same-cycle accept is discarded.
  - A same-cycle pop still completes; downstream owns kill of the popped op.
- Reset (rst_n low, asynchronous):
  - H.valid=S.valid=0, so out_valid=0 and rd_wen_o=0.
  - in_ready=1.
  - All data registers=0, so aluop_o=0, op1/op2/store_data/pc_o=0, rd_o=0.
  - Reset mid-stall drops both entries; there is no partial state.
- Data outputs while out_valid=0 are don't-care except rd_wen_o, which is forced to 0.

Decomposition:
- Shared include define.v holds RegBus, aluopLength, plus new OP1_SEL_*/OP2_SEL_* encodings and a RegAddrBus (4:0) width macro.
- One sub-module: idex_slot.
  - One entry register with load/clear and per-source write-back snoop.
  - Instantiated twice (H, S).
- The top level holds the handshake/steering logic and the output mux.

Test Plan:
- Reset then accept {pc=0x80000000, rs1_data=5, imm=7, aluop=0000, sel1=00, sel2=01} -> next cycle out_valid=1, op1=5, op2=7, in_ready=1.
- out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 after the 2nd; release out_ready -> entries emerge in order, none lost or duplicated.
- Hold an entry with rs1=3, stored 0x10; pulse wb_wen, wb_rd=3, wb_data=0xAB while stalled -> op1 becomes 0xAB and stays after wb_wen drops.
- mem_wen=1, mem_rd=2, mem_data=0x55 with head rs2=2, sel2=00 -> op2=0x55, store_data=0x55; same with rs2=0 -> op2=0.
- Both slots full, flush_i=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, new op not captured.
- Assert rst_n=0 mid-stall with both slots full -> out_valid and rd_wen_o drop immediately (asynchronous); after release in_ready=1.

Source files
------------

// File: rtl/idex_stage_pkg.sv
// Shared widths, operand-select encodings and source-match helper for the ID/EX stage.
package idex_stage_pkg;

  localparam int REG_BUS      = 64;
  localparam int ALUOP_LENGTH = 4;
  localparam int REG_ADDR_W   = 5;

  typedef enum logic [1:0] {
    OP1_SEL_RS1  = 2'b00,
    OP1_SEL_PC   = 2'b01,
    OP1_SEL_ZERO = 2'b10,
    OP1_SEL_RSVD = 2'b11
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_SEL_RS2  = 2'b00,
    OP2_SEL_IMM  = 2'b01,
    OP2_SEL_FOUR = 2'b10,
    OP2_SEL_RSVD = 2'b11
  } op2_sel_e;

  // x0 never matches, so a write to rd 0 can never overwrite a source value.
  function automatic logic src_hit(
    input logic                  wen,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs
  );
    return wen && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/idex_slot.sv
// One micro-op entry with load/clear and write-back snooping on both sources.
module idex_slot
  import idex_stage_pkg::*;
#(
  parameter int XLEN      = REG_BUS,
  parameter int PAYLOAD_W = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_load,
  input  logic                           i_clear,
  input  logic [PAYLOAD_W-1:0]           i_payload,
  input  logic [1:0][REG_ADDR_W-1:0]     i_rs,
  input  logic [1:0][XLEN-1:0]           i_rs_data,
  input  logic                           i_wb_wen,
  input  logic [REG_ADDR_W-1:0]          i_wb_rd,
  input  logic [XLEN-1:0]                i_wb_data,
  output logic                           o_valid,
  output logic [PAYLOAD_W-1:0]           o_payload,
  output logic [1:0][REG_ADDR_W-1:0]     o_rs,
  output logic [1:0][XLEN-1:0]           o_rs_data
);

  logic                       r_valid;
  logic [PAYLOAD_W-1:0]       r_payload;
  logic [1:0][REG_ADDR_W-1:0] r_rs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_rs      <= '0;
    end else begin
      if (i_clear)
        r_valid <= 1'b0;
      else if (i_load)
        r_valid <= 1'b1;
      if (i_load) begin
        r_payload <= i_payload;
        r_rs      <= i_rs;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [REG_ADDR_W-1:0] w_rs;
      logic [XLEN-1:0]       w_data;
      logic [XLEN-1:0]       r_data;

      // Snoop applies to whatever is being written, so loads capture forwarded data too.
      assign w_rs   = i_load ? i_rs[gi]      : r_rs[gi];
      assign w_data = i_load ? i_rs_data[gi] : r_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_data <= '0;
        else if (src_hit(i_wb_wen, i_wb_rd, w_rs))
          r_data <= i_wb_data;
        else
          r_data <= w_data;
      end

      assign o_rs_data[gi] = r_data;
    end
  endgenerate

  assign o_valid   = r_valid;
  assign o_payload = r_payload;
  assign o_rs      = r_rs;

endmodule

// File: rtl/idex_stage.sv
// Decode-to-execute stage: 2-entry skid buffer, write-back snoop and MEM bypass into ALU operands.
module idex_stage
  import idex_stage_pkg::*;
#(
  parameter int XLEN    = REG_BUS,
  parameter int ALUOP_W = ALUOP_LENGTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i_idex,
  output logic                  in_ready_o_idex,
  input  logic [XLEN-1:0]       pc_i_idex,
  input  logic [REG_ADDR_W-1:0] rs1_i_idex,
  input  logic [REG_ADDR_W-1:0] rs2_i_idex,
  input  logic [XLEN-1:0]       rs1_data_i_idex,
  input  logic [XLEN-1:0]       rs2_data_i_idex,
  input  logic [XLEN-1:0]       imm_i_idex,
  input  logic [ALUOP_W-1:0]    aluop_i_idex,
  input  logic [1:0]            op1_sel_i_idex,
  input  logic [1:0]            op2_sel_i_idex,
  input  logic [REG_ADDR_W-1:0] rd_i_idex,
  input  logic                  rd_wen_i_idex,
  input  logic                  flush_i_idex,
  input  logic                  mem_wen_i_idex,
  input  logic [REG_ADDR_W-1:0] mem_rd_i_idex,
  input  logic [XLEN-1:0]       mem_data_i_idex,
  input  logic                  wb_wen_i_idex,
  input  logic [REG_ADDR_W-1:0] wb_rd_i_idex,
  input  logic [XLEN-1:0]       wb_data_i_idex,
  output logic                  out_valid_o_idex,
  input  logic                  out_ready_i_idex,
  output logic [ALUOP_W-1:0]    aluop_o_idex,
  output logic [XLEN-1:0]       op1_o_idex,
  output logic [XLEN-1:0]       op2_o_idex,
  output logic [XLEN-1:0]       store_data_o_idex,
  output logic [XLEN-1:0]       pc_o_idex,
  output logic [REG_ADDR_W-1:0] rd_o_idex,
  output logic                  rd_wen_o_idex
);

  localparam int PAYLOAD_W = 2*XLEN + ALUOP_W + 2 + 2 + REG_ADDR_W + 1;

  logic                       r_in_ready;
  logic                       w_accept, w_pop, w_h_from_s;
  logic                       w_h_load, w_h_clear, w_s_load, w_s_clear;

  logic [PAYLOAD_W-1:0]       w_in_payload, w_h_in_payload;
  logic [1:0][REG_ADDR_W-1:0] w_in_rs, w_h_in_rs;
  logic [1:0][XLEN-1:0]       w_in_rs_data, w_h_in_rs_data;

  logic                       w_h_valid, w_s_valid;
  logic [PAYLOAD_W-1:0]       w_h_payload, w_s_payload;
  logic [1:0][REG_ADDR_W-1:0] w_h_rs, w_s_rs;
  logic [1:0][XLEN-1:0]       w_h_rs_data, w_s_rs_data;

  logic [XLEN-1:0]            w_h_pc, w_h_imm;
  logic [ALUOP_W-1:0]         w_h_aluop;
  logic [1:0]                 w_h_op1_sel, w_h_op2_sel;
  logic [REG_ADDR_W-1:0]      w_h_rd;
  logic                       w_h_rd_wen;
  logic [1:0][XLEN-1:0]       w_src;

  assign w_accept   = in_valid_i_idex & r_in_ready;
  assign w_pop      = w_h_valid & out_ready_i_idex;
  assign w_h_from_s = w_pop & w_s_valid;

  // in_ready is low whenever S is valid, so an accept never coincides with an S->H move.
  assign w_h_load  = ~flush_i_idex & (w_h_from_s | (w_accept & (~w_h_valid | w_pop)));
  assign w_s_load  = ~flush_i_idex & w_accept & w_h_valid & ~w_pop;
  assign w_h_clear = flush_i_idex | (w_pop & ~w_h_load);
  assign w_s_clear = flush_i_idex | w_h_from_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_in_ready <= 1'b1;
    else if (w_s_clear)
      r_in_ready <= 1'b1;
    else if (w_s_load)
      r_in_ready <= 1'b0;
  end

  assign w_in_payload = {pc_i_idex, imm_i_idex, aluop_i_idex, op1_sel_i_idex,
                         op2_sel_i_idex, rd_i_idex, rd_wen_i_idex};
  assign w_in_rs      = {rs2_i_idex, rs1_i_idex};
  assign w_in_rs_data = {rs2_data_i_idex, rs1_data_i_idex};

  assign w_h_in_payload = w_h_from_s ? w_s_payload : w_in_payload;
  assign w_h_in_rs      = w_h_from_s ? w_s_rs      : w_in_rs;
  assign w_h_in_rs_data = w_h_from_s ? w_s_rs_data : w_in_rs_data;

  idex_slot #(.XLEN(XLEN), .PAYLOAD_W(PAYLOAD_W)) u_head (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_h_load),
    .i_clear   (w_h_clear),
    .i_payload (w_h_in_payload),
    .i_rs      (w_h_in_rs),
    .i_rs_data (w_h_in_rs_data),
    .i_wb_wen  (wb_wen_i_idex),
    .i_wb_rd   (wb_rd_i_idex),
    .i_wb_data (wb_data_i_idex),
    .o_valid   (w_h_valid),
    .o_payload (w_h_payload),
    .o_rs      (w_h_rs),
    .o_rs_data (w_h_rs_data)
  );

  idex_slot #(.XLEN(XLEN), .PAYLOAD_W(PAYLOAD_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_s_load),
    .i_clear   (w_s_clear),
    .i_payload (w_in_payload),
    .i_rs      (w_in_rs),
    .i_rs_data (w_in_rs_data),
    .i_wb_wen  (wb_wen_i_idex),
    .i_wb_rd   (wb_rd_i_idex),
    .i_wb_data (wb_data_i_idex),
    .o_valid   (w_s_valid),
    .o_payload (w_s_payload),
    .o_rs      (w_s_rs),
    .o_rs_data (w_s_rs_data)
  );

  assign {w_h_pc, w_h_imm, w_h_aluop, w_h_op1_sel, w_h_op2_sel, w_h_rd, w_h_rd_wen} = w_h_payload;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bypass
      assign w_src[gi] = src_hit(mem_wen_i_idex, mem_rd_i_idex, w_h_rs[gi]) ?
                         mem_data_i_idex : w_h_rs_data[gi];
    end
  endgenerate

  always_comb begin
    op1_o_idex = '0;
    case (op1_sel_e'(w_h_op1_sel))
      OP1_SEL_RS1: op1_o_idex = w_src[0];
      OP1_SEL_PC:  op1_o_idex = w_h_pc;
      default:     op1_o_idex = '0;
    endcase
  end

  always_comb begin
    op2_o_idex = '0;
    case (op2_sel_e'(w_h_op2_sel))
      OP2_SEL_RS2:  op2_o_idex = w_src[1];
      OP2_SEL_IMM:  op2_o_idex = w_h_imm;
      OP2_SEL_FOUR: op2_o_idex = XLEN'(4);
      default:      op2_o_idex = '0;
    endcase
  end

  assign in_ready_o_idex   = r_in_ready;
  assign out_valid_o_idex  = w_h_valid;
  assign aluop_o_idex      = w_h_aluop;
  assign store_data_o_idex = w_src[1];
  assign pc_o_idex         = w_h_pc;
  assign rd_o_idex         = w_h_rd;
  assign rd_wen_o_idex     = w_h_valid & w_h_rd_wen;

endmodule

// File: tb/tb_idex_stage.sv
// Scoreboard bench for idex_stage: queue-based reference model plus directed scenarios and random traffic.
module tb_idex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0] pc, rs1_data, rs2_data, imm, mem_data, wb_data;
  logic [4:0]  rs1, rs2, rd, mem_rd, wb_rd, rd_o;
  logic [3:0]  aluop, aluop_o;
  logic [1:0]  sel1, sel2;
  logic        rd_wen, mem_wen, wb_wen, rd_wen_o;
  logic [63:0] op1_o, op2_o, store_o, pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  idex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i_idex(in_valid), .in_ready_o_idex(in_ready),
    .pc_i_idex(pc), .rs1_i_idex(rs1), .rs2_i_idex(rs2),
    .rs1_data_i_idex(rs1_data), .rs2_data_i_idex(rs2_data),
    .imm_i_idex(imm), .aluop_i_idex(aluop),
    .op1_sel_i_idex(sel1), .op2_sel_i_idex(sel2),
    .rd_i_idex(rd), .rd_wen_i_idex(rd_wen), .flush_i_idex(flush),
    .mem_wen_i_idex(mem_wen), .mem_rd_i_idex(mem_rd), .mem_data_i_idex(mem_data),
    .wb_wen_i_idex(wb_wen), .wb_rd_i_idex(wb_rd), .wb_data_i_idex(wb_data),
    .out_valid_o_idex(out_valid), .out_ready_i_idex(out_ready),
    .aluop_o_idex(aluop_o), .op1_o_idex(op1_o), .op2_o_idex(op2_o),
    .store_data_o_idex(store_o), .pc_o_idex(pc_o), .rd_o_idex(rd_o),
    .rd_wen_o_idex(rd_wen_o)
  );

  typedef struct {
    logic [63:0] pc, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_wen;
    logic [3:0]  aluop;
    logic [1:0]  s1, s2;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hit(input logic wen, input logic [4:0] wrd, input logic [4:0] rs);
    return wen && wrd == rs && rs != 5'd0;
  endfunction

  // Reference: an ordered list of at most two ops whose source values follow write-back.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      automatic logic exp_ready = (q.size() < 2);
      automatic ent_t e;
      automatic logic [63:0] s1v, s2v, e1, e2;
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("rd_wen_o", {63'd0, rd_wen_o}, {63'd0, (q.size() > 0) ? q[0].rd_wen : 1'b0});
      if (q.size() > 0 && out_ready) begin
        e   = q.pop_front();
        s1v = hit(mem_wen, mem_rd, e.rs1) ? mem_data : e.d1;
        s2v = hit(mem_wen, mem_rd, e.rs2) ? mem_data : e.d2;
        e1  = (e.s1 == 2'd0) ? s1v : (e.s1 == 2'd1) ? e.pc : 64'd0;
        e2  = (e.s2 == 2'd0) ? s2v : (e.s2 == 2'd1) ? e.imm : (e.s2 == 2'd2) ? 64'd4 : 64'd0;
        chk("pop_aluop", {60'd0, aluop_o}, {60'd0, e.aluop});
        chk("pop_op1", op1_o, e1);
        chk("pop_op2", op2_o, e2);
        chk("pop_store", store_o, s2v);
        chk("pop_pc", pc_o, e.pc);
        chk("pop_rd", {59'd0, rd_o}, {59'd0, e.rd});
        $display("[TB] pop pc=%h op1=%h op2=%h", pc_o, op1_o, op2_o);
      end
      if (flush) begin
        q.delete();
      end else begin
        foreach (q[i]) begin
          if (hit(wb_wen, wb_rd, q[i].rs1)) q[i].d1 = wb_data;
          if (hit(wb_wen, wb_rd, q[i].rs2)) q[i].d2 = wb_data;
        end
        if (in_valid && exp_ready) begin
          e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.rd_wen = rd_wen;
          e.aluop = aluop; e.s1 = sel1; e.s2 = sel2;
          e.d1 = hit(wb_wen, wb_rd, rs1) ? wb_data : rs1_data;
          e.d2 = hit(wb_wen, wb_rd, rs2) ? wb_data : rs2_data;
          q.push_back(e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; mem_wen = 0; wb_wen = 0;
    pc = '0; rs1 = '0; rs2 = '0; rs1_data = '0; rs2_data = '0; imm = '0;
    aluop = '0; sel1 = '0; sel2 = '0; rd = '0; rd_wen = 0;
    mem_rd = '0; mem_data = '0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic offer(input logic [63:0] p, input logic [4:0] r1, input logic [63:0] d1,
                       input logic [4:0] r2, input logic [63:0] d2, input logic [63:0] im,
                       input logic [1:0] s1, input logic [1:0] s2);
    in_valid = 1; pc = p; rs1 = r1; rs1_data = d1; rs2 = r2; rs2_data = d2; imm = im;
    sel1 = s1; sel2 = s2; aluop = p[3:0]; rd = p[8:4]; rd_wen = 1;
  endtask

  initial begin
    rst_n = 0; out_ready = 0;
    idle();
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_rd_wen", {63'd0, rd_wen_o}, 64'd0);
    chk("rst_op1", op1_o, 64'd0);
    chk("rst_op2", op2_o, 64'd0);
    chk("rst_pc", pc_o, 64'd0);
    chk("rst_aluop", {60'd0, aluop_o}, 64'd0);
    rst_n = 1;

    // Single op: 1-cycle latency, rs1 and imm operands.
    cyc();
    offer(64'h8000_0000, 5'd1, 64'd5, 5'd0, 64'd0, 64'd7, 2'b00, 2'b01);
    aluop = 4'b0000;
    cyc(); idle(); #1;
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_op1", op1_o, 64'd5);
    chk("t1_op2", op2_o, 64'd7);
    chk("t1_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1; cyc(); out_ready = 0;

    // Stall: two accepted, third refused, then drained in order.
    offer(64'hA00, 5'd1, 64'h11, 5'd2, 64'h12, 64'h13, 2'b01, 2'b10);
    cyc(); offer(64'hB00, 5'd3, 64'h21, 5'd0, 64'h0, 64'h23, 2'b00, 2'b01); #1;
    chk("t2_ready_after1", {63'd0, in_ready}, 64'd1);
    cyc(); offer(64'hC00, 5'd1, 64'h31, 5'd1, 64'h32, 64'h33, 2'b00, 2'b00); #1;
    chk("t2_ready_after2", {63'd0, in_ready}, 64'd0);
    chk("t2_head_a", pc_o, 64'hA00);
    cyc(); idle(); out_ready = 1; #1;
    chk("t2_head_still_a", pc_o, 64'hA00);
    cyc(); #1;
    chk("t2_head_b", pc_o, 64'hB00);
    chk("t2_ready_drain", {63'd0, in_ready}, 64'd1);
    cyc(); #1;
    chk("t2_empty", {63'd0, out_valid}, 64'd0);
    out_ready = 0;

    // Write-back snoop while stalled.
    offer(64'hD00, 5'd3, 64'h10, 5'd0, 64'h0, 64'h1, 2'b00, 2'b01);
    cyc(); idle(); wb_wen = 1; wb_rd = 5'd3; wb_data = 64'hAB; #1;
    chk("t3_op1_before", op1_o, 64'h10);
    cyc(); wb_wen = 0; #1;
    chk("t3_op1_snooped", op1_o, 64'hAB);
    cyc(); #1;
    chk("t3_op1_held", op1_o, 64'hAB);
    out_ready = 1; cyc(); out_ready = 0;

    // MEM bypass on rs2, and no bypass for x0.
    offer(64'hE00, 5'd0, 64'h0, 5'd2, 64'h22, 64'h1, 2'b10, 2'b00);
    cyc(); idle(); mem_wen = 1; mem_rd = 5'd2; mem_data = 64'h55; #1;
    chk("t4_op2_bypass", op2_o, 64'h55);
    chk("t4_store_bypass", store_o, 64'h55);
    out_ready = 1; cyc(); out_ready = 0;
    offer(64'hF00, 5'd0, 64'h0, 5'd0, 64'h0, 64'h1, 2'b10, 2'b00);
    mem_wen = 1; mem_rd = 5'd0; mem_data = 64'h55;
    cyc(); in_valid = 0; #1;
    chk("t4_op2_x0", op2_o, 64'd0);
    chk("t4_store_x0", store_o, 64'd0);
    out_ready = 1; cyc(); out_ready = 0; idle();

    // Flush with both slots full and a new op offered.
    offer(64'h1100, 5'd1, 64'h1, 5'd2, 64'h2, 64'h3, 2'b00, 2'b00);
    cyc(); offer(64'h1200, 5'd1, 64'h1, 5'd2, 64'h2, 64'h3, 2'b01, 2'b01);
    cyc(); offer(64'h1300, 5'd1, 64'h1, 5'd2, 64'h2, 64'h3, 2'b01, 2'b01); flush = 1;
    cyc(); idle(); #1;
    chk("t5_flush_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_flush_ready", {63'd0, in_ready}, 64'd1);
    cyc(); #1;
    chk("t5_not_captured", {63'd0, out_valid}, 64'd0);

    // Flush discards a same-cycle accept while in_ready is high.
    offer(64'h1400, 5'd1, 64'h1, 5'd2, 64'h2, 64'h3, 2'b01, 2'b01);
    cyc(); offer(64'h1500, 5'd1, 64'h1, 5'd2, 64'h2, 64'h3, 2'b01, 2'b01); flush = 1;
    cyc(); idle(); #1;
    chk("t5b_flush_accept", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset mid-stall.
    offer(64'h1600, 5'd1, 64'h1, 5'd2, 64'h2, 64'h3, 2'b01, 2'b01);
    cyc(); offer(64'h1700, 5'd1, 64'h1, 5'd2, 64'h2, 64'h3, 2'b01, 2'b01);
    cyc(); idle(); #2;
    rst_n = 0; #1;
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_rd_wen", {63'd0, rd_wen_o}, 64'd0);
    chk("t6_rst_pc", pc_o, 64'd0);
    @(negedge clk); #2; rst_n = 1;
    cyc(); #1;
    chk("t6_ready_after", {63'd0, in_ready}, 64'd1);
    chk("t6_valid_after", {63'd0, out_valid}, 64'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      automatic int phase = (n / 100) % 3;
      in_valid = ($urandom_range(0, 2) != 0);
      pc       = {$urandom(), $urandom()};
      imm      = {$urandom(), $urandom()};
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      rs1_data = (rs1 == 0) ? 64'd0 : {$urandom(), $urandom()};
      rs2_data = (rs2 == 0) ? 64'd0 : {$urandom(), $urandom()};
      aluop    = 4'($urandom());
      sel1     = 2'($urandom());
      sel2     = 2'($urandom());
      rd       = 5'($urandom());
      rd_wen   = 1'($urandom());
      flush    = ($urandom_range(0, 31) == 0);
      wb_wen   = 1'($urandom());
      wb_rd    = 5'($urandom_range(0, 3));
      wb_data  = {$urandom(), $urandom()};
      mem_wen  = 1'($urandom());
      mem_rd   = 5'($urandom_range(0, 3));
      mem_data = {$urandom(), $urandom()};
      out_ready = (phase == 0) ? 1'b1 : (phase == 1) ? ($urandom_range(0, 3) == 0)
                                                     : 1'($urandom());
      cyc();
    end
    idle(); out_ready = 1;
    repeat (4) cyc();
    chk("final_drained", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
